// File: rtl/id_stage.sv
// Decode stage of a 5-stage RV32 pipeline: static branch predecode, load-use
// hazard detection, squash tracking, stall hold register and the ID/EX register.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        ex_stall,
    input  logic        ex_br_mispred,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    output logic [31:0] id_target,
    output logic        id_target_taken,
    output logic        id_stall,
    output logic        dx_valid,
    output logic [31:0] dx_instr,
    output logic [31:0] dx_pc,
    output logic        dx_pred_taken
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic            valid_q, valid_d;
    logic            hold_vld_q, hold_vld_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic            dx_valid_q, dx_valid_d;
    logic [XLEN-1:0] dx_instr_q, dx_instr_d;
    logic [XLEN-1:0] dx_pc_q, dx_pc_d;
    logic            dx_pred_q, dx_pred_d;

    logic [XLEN-1:0] cur_instr, cur_pc;
    logic [6:0]      opcode;
    logic [RW-1:0]   rs1, rs2;
    logic            is_jal, is_br, uses_rs1, uses_rs2;
    logic [XLEN-1:0] j_imm, b_imm;
    logic            hazard, predict, stall_any;

    // Instruction in the slot: held copy wins over live imem data while stalled
    always_comb begin
        cur_instr = hold_vld_q ? hold_instr_q : if_instr;
        cur_pc    = hold_vld_q ? hold_pc_q    : if_pc;
        opcode    = cur_instr[6:0];
        rs1       = cur_instr[19:15];
        rs2       = cur_instr[24:20];
        is_jal    = (opcode == OP_JAL);
        is_br     = (opcode == OP_BRANCH);
        uses_rs1  = (opcode == OP_JALR) || is_br || (opcode == OP_LOAD) ||
                    (opcode == OP_STORE) || (opcode == OP_IMM) || (opcode == OP_REG);
        uses_rs2  = is_br || (opcode == OP_STORE) || (opcode == OP_REG);
        j_imm     = {{11{cur_instr[31]}}, cur_instr[31], cur_instr[19:12],
                     cur_instr[20], cur_instr[30:21], 1'b0};
        b_imm     = {{19{cur_instr[31]}}, cur_instr[31], cur_instr[7],
                     cur_instr[30:25], cur_instr[11:8], 1'b0};
    end

    // Hazard detection and backward-taken/forward-not-taken prediction
    always_comb begin
        hazard          = valid_q && ex_is_load && (ex_rd != RW'(0)) &&
                          ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
        id_stall        = hazard && !ex_br_mispred && !rst;
        predict         = is_jal || (is_br && cur_instr[31]);
        id_target       = cur_pc + (is_jal ? j_imm : b_imm);
        id_target_taken = predict && valid_q && !rst && !ex_br_mispred &&
                          !ex_stall && !id_stall;
        stall_any       = ex_stall || id_stall;
    end

    // Next-state: slot validity, hold register and ID/EX priority chain
    always_comb begin
        valid_d      = 1'b1;
        hold_vld_d   = hold_vld_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        dx_valid_d   = valid_q;
        dx_instr_d   = cur_instr;
        dx_pc_d      = cur_pc;
        dx_pred_d    = id_target_taken;

        if (ex_br_mispred) begin
            valid_d    = 1'b0;
            hold_vld_d = 1'b0;
        end else if (stall_any) begin
            valid_d = valid_q;
            if (!hold_vld_q) begin
                hold_vld_d   = 1'b1;
                hold_instr_d = if_instr;
                hold_pc_d    = if_pc;
            end
        end else begin
            valid_d    = !id_target_taken;
            hold_vld_d = 1'b0;
        end

        if (ex_br_mispred || (!ex_stall && id_stall)) begin
            dx_valid_d = 1'b0;
            dx_instr_d = NOP;
            dx_pc_d    = dx_pc_q;
            dx_pred_d  = 1'b0;
        end else if (ex_stall) begin
            dx_valid_d = dx_valid_q;
            dx_instr_d = dx_instr_q;
            dx_pc_d    = dx_pc_q;
            dx_pred_d  = dx_pred_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc_q    <= RESET_PC;
            dx_valid_q   <= 1'b0;
            dx_instr_q   <= NOP;
            dx_pc_q      <= RESET_PC;
            dx_pred_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            hold_vld_q   <= hold_vld_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            dx_valid_q   <= dx_valid_d;
            dx_instr_q   <= dx_instr_d;
            dx_pc_q      <= dx_pc_d;
            dx_pred_q    <= dx_pred_d;
        end
    end

    assign dx_valid      = dx_valid_q;
    assign dx_instr      = dx_instr_q;
    assign dx_pc         = dx_pc_q;
    assign dx_pred_taken = dx_pred_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h4000_0000, the PC loaded into dx_pc on reset.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port if_instr  input  32  imem read data for the fetch address presented on the previous cycle.
REQ-005 The block SHALL have port if_pc  input  32  PC register value matching if_instr.
REQ-006 The block SHALL have port ex_stall  input  1  EX cannot accept; freeze ID and ID/EX.
REQ-007 The block SHALL have port ex_br_mispred  input  1  EX redirect; squash younger instructions.
REQ-008 The block SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-009 The block SHALL have port ex_is_load  input  1  instruction in EX is a valid load.
REQ-010 The block SHALL have port id_target  output  32  predicted redirect address (combinational).
REQ-011 The block SHALL have port id_target_taken  output  1  redirect fetch to id_target (combinational).
REQ-012 The block SHALL have port id_stall  output  1  load-use hazard; hold PC (combinational).
REQ-013 The block SHALL have ports dx_valid / dx_instr / dx_pc / dx_pred_taken  output  1/32/32/1  registered ID/EX contents.

Function
REQ-014 The block SHALL hold a 1-bit valid flag for the ID slot; the flag SHALL be 0 in the cycle after reset (imem output undefined) and in the cycle after any squash.
REQ-015 In the first cycle of any stall (ex_stall or id_stall), the block SHALL capture if_instr/if_pc into a hold register and SHALL use the held values in place of if_instr/if_pc until the first non-stalled cycle, inclusive.
REQ-016 Predecode: JAL (opcode 1101111) SHALL give id_target = pc + sign-extended J-immediate, taken = 1.
REQ-017 Predecode: conditional branch (opcode 1100011) with B-immediate sign bit = 1 SHALL give id_target = pc + B-immediate, taken = 1; with sign bit = 0, taken = 0 (backward-taken/forward-not-taken).
REQ-018 JALR and all other opcodes SHALL give taken = 0; id_target SHALL then be don't-care; all address arithmetic SHALL be 32-bit modulo 2^32.
REQ-019 id_target_taken SHALL be forced to 0 when the slot is invalid, ex_br_mispred = 1, ex_stall = 1 or id_stall = 1.
REQ-020 id_stall SHALL be 1 when the slot is valid, ex_is_load = 1, ex_rd != 0, and ex_rd equals rs1 (for opcodes reading rs1) or rs2 (for R, S, B types); it SHALL be 0 during ex_br_mispred.
REQ-021 After a cycle with id_target_taken = 1, the next arriving instruction (wrong path, pc+4) SHALL be marked invalid.
REQ-022 On ex_br_mispred, the current ID instruction and the next arriving instruction SHALL be marked invalid; ex_br_mispred SHALL override all stall conditions.
REQ-023 ID/EX update priority SHALL be: rst > ex_br_mispred (load a bubble) > ex_stall (hold) > id_stall (load a bubble) > normal (load slot valid, instr, pc, taken).
REQ-024 A bubble SHALL be dx_valid = 0, dx_instr = 32'h0000_0013 (NOP), dx_pred_taken = 0, with dx_pc unchanged.

Reset
REQ-025 While rst = 1, the block SHALL set dx_valid = 0, dx_instr = 32'h0000_0013, dx_pc = RESET_PC, dx_pred_taken = 0, slot valid = 0, hold register empty and squash flags cleared; reset mid-stall SHALL discard held instructions.
REQ-026 During reset and the following cycle, id_target_taken and id_stall SHALL be 0.

Verification
REQ-027 The bench SHALL check: JAL at pc 0x4000_0010 with imm +0x100 -> id_target = 0x4000_0110, id_target_taken = 1; next instruction -> dx_valid = 0.
REQ-028 The bench SHALL check: BEQ at 0x4000_0020 with imm -8 -> target 0x4000_0018, taken = 1, dx_pred_taken = 1 next cycle; imm +8 -> taken = 0.
REQ-029 The bench SHALL check: ex_is_load = 1, ex_rd = x5, ID ADD x6,x5,x7 -> id_stall = 1, dx bubble; next cycle (load leaves EX) -> ADD enters dx with correct pc; ex_rd = x0 -> no stall.
REQ-030 The bench SHALL check: ex_stall held 3 cycles while imem data changes -> dx_* unchanged, original instruction issued after release, no duplicate or lost instruction.
REQ-031 The bench SHALL check: ex_br_mispred with ID holding a JAL and id_stall conditions true -> id_target_taken = 0, id_stall = 0, dx bubble, next arriving instruction invalid.
REQ-032 The bench SHALL check: rst asserted mid-stall -> dx_pc = 0x4000_0000, dx_valid = 0; first post-reset instruction issues in the second cycle after reset release.
